// File: rtl/memory_controller_burst_param.sv
// Burst memory front-end: one valid/ready request of 1..MAX_BURST words, serialised to a byte-wide PSRAM PHY.
// Define MEMCTL_BYTESWAP_EN to serialise/assemble bytes LSB first; otherwise MSB first.
module memory_controller_burst_param #(
  parameter  int DATA_W    = 32,
  parameter  int ADDR_W    = 22,
  parameter  int MAX_BURST = 256,
  localparam int BPW       = DATA_W / 8,
  localparam int LEN_W     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1,
  localparam int AB_W      = $clog2(BPW),
  localparam int BIDX_W    = (BPW > 1) ? $clog2(BPW) : 1,
  localparam int PA_W      = ADDR_W + AB_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              done,
  output logic              busy,
  output logic              err,
  output logic              phy_rd,
  output logic              phy_we,
  output logic              phy_rend,
  output logic              phy_wend,
  output logic [PA_W-1:0]   phy_a,
  output logic [7:0]        phy_din,
  input  logic [7:0]        phy_dout,
  input  logic              phy_byte_available,
  input  logic              phy_ready_for_next_byte,
  input  logic              phy_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_PHY, S_START, S_XFER, S_FINISH
  } state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [BIDX_W-1:0]   bidx_q, bidx_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                shift_full_q, shift_full_d;
  logic [DATA_W-1:0]   pf_q, pf_d;
  logic                pf_full_q, pf_full_d;
  logic [DATA_W-1:0]   asm_q, asm_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic                err_q, err_d;
  logic                ba_prev_q, rfnb_prev_q;

  logic                ba_rise, rfnb_rise, byte_evt;
  logic                last_byte, last_word;
  logic [DATA_W-1:0]   shift_next, asm_next;
  logic [7:0]          cur_byte;

  assign ba_rise   = phy_byte_available & ~ba_prev_q;
  assign rfnb_rise = phy_ready_for_next_byte & ~rfnb_prev_q;
  assign byte_evt  = we_q ? rfnb_rise : ba_rise;
  assign last_byte = (bidx_q == BIDX_W'(BPW - 1));
  assign last_word = (cnt_q == '0);

`ifdef MEMCTL_BYTESWAP_EN
  assign cur_byte   = shift_q[7:0];
  assign shift_next = shift_q >> 8;
  assign asm_next   = (asm_q >> 8) | (DATA_W'(phy_dout) << (DATA_W - 8));
`else
  assign cur_byte   = shift_q[DATA_W-1 -: 8];
  assign shift_next = shift_q << 8;
  assign asm_next   = (asm_q << 8) | DATA_W'(phy_dout);
`endif

  // NOTE: every _d gets its default before the case so no path leaves a variable unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    bidx_d       = bidx_q;
    shift_d      = shift_q;
    shift_full_d = shift_full_q;
    pf_d         = pf_q;
    pf_full_d    = pf_full_q;
    asm_d        = asm_q;
    rdata_d      = rdata_q;
    rvalid_d     = 1'b0;
    err_d        = err_q;

    // Prefetch fill and drain are mutually exclusive: fill needs it empty, drain needs it full.
    if (wdata_valid && !pf_full_q) begin
      pf_d      = wdata;
      pf_full_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          cnt_d   = req_len;
          bidx_d  = '0;
          err_d   = 1'b0;
          state_d = S_WAIT_PHY;
        end
      end
      S_WAIT_PHY: begin
        if (we_q && !shift_full_q && pf_full_q) begin
          shift_d      = pf_q;
          shift_full_d = 1'b1;
          pf_full_d    = 1'b0;
        end
        if (phy_ready && (!we_q || shift_full_q)) state_d = S_START;
      end
      S_START: state_d = S_XFER;
      S_XFER: begin
        if (byte_evt) begin
          if (we_q) shift_d = shift_next;
          else      asm_d   = asm_next;
          if (last_byte) begin
            if (!we_q) begin
              rdata_d  = asm_next;
              rvalid_d = 1'b1;
            end
            if (last_word) begin
              // Counters stay at their terminal values so phy_rend holds through FINISH.
              state_d      = S_FINISH;
              shift_full_d = 1'b0;
            end else begin
              cnt_d  = cnt_q - LEN_W'(1);
              bidx_d = '0;
              if (we_q) begin
                if (pf_full_q) begin
                  shift_d   = pf_q;
                  pf_full_d = 1'b0;
                end else begin
                  shift_d = '0;
                  err_d   = 1'b1;
                end
              end
            end
          end else begin
            bidx_d = bidx_q + BIDX_W'(1);
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together on the edge.
  // NOTE: data registers are reset as well so every output is defined (0) straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      cnt_q        <= '0;
      bidx_q       <= '0;
      shift_q      <= '0;
      shift_full_q <= 1'b0;
      pf_q         <= '0;
      pf_full_q    <= 1'b0;
      asm_q        <= '0;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
      err_q        <= 1'b0;
      ba_prev_q    <= 1'b0;
      rfnb_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      bidx_q       <= bidx_d;
      shift_q      <= shift_d;
      shift_full_q <= shift_full_d;
      pf_q         <= pf_d;
      pf_full_q    <= pf_full_d;
      asm_q        <= asm_d;
      rdata_q      <= rdata_d;
      rvalid_q     <= rvalid_d;
      err_q        <= err_d;
      ba_prev_q    <= phy_byte_available;
      rfnb_prev_q  <= phy_ready_for_next_byte;
    end
  end

  // Handshake readies are forced low while reset is asserted.
  assign req_ready   = rst_n && (state_q == S_IDLE);
  assign wdata_ready = rst_n && !pf_full_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_FINISH);
  assign err         = err_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rvalid_q;
  assign phy_rd      = (state_q == S_START) && !we_q;
  assign phy_we      = (state_q == S_START) && we_q;
  assign phy_wend    = (state_q == S_FINISH) && we_q;
  assign phy_rend    = !we_q && last_word && last_byte &&
                       (state_q inside {S_START, S_XFER, S_FINISH});
  assign phy_a       = PA_W'(addr_q) << AB_W;
  assign phy_din     = cur_byte;

endmodule

// File: tb/tb_memory_controller_burst_param.sv
// Directed bench for memory_controller_burst_param: default 32-bit instance plus a 16-bit, 4-deep instance.
module tb_memory_controller_burst_param;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        req_valid, req_ready, req_we;
  logic [21:0] req_addr;
  logic [7:0]  req_len;
  logic [31:0] wdata, rdata;
  logic        wdata_valid, wdata_ready, rdata_valid, done, busy, err;
  logic        phy_rd, phy_we, phy_rend, phy_wend;
  logic [23:0] phy_a;
  logic [7:0]  phy_din, phy_dout;
  logic        phy_byte_available, phy_ready_for_next_byte, phy_ready;

  memory_controller_burst_param dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid), .done(done), .busy(busy), .err(err),
    .phy_rd(phy_rd), .phy_we(phy_we), .phy_rend(phy_rend), .phy_wend(phy_wend),
    .phy_a(phy_a), .phy_din(phy_din), .phy_dout(phy_dout),
    .phy_byte_available(phy_byte_available),
    .phy_ready_for_next_byte(phy_ready_for_next_byte), .phy_ready(phy_ready)
  );

  // 16-bit, MAX_BURST=4 instance
  logic        req_valid_s, req_ready_s, req_we_s;
  logic [7:0]  req_addr_s;
  logic [1:0]  req_len_s;
  logic [15:0] wdata_s, rdata_s;
  logic        wdata_valid_s, wdata_ready_s, rdata_valid_s, done_s, busy_s, err_s;
  logic        phy_rd_s, phy_we_s, phy_rend_s, phy_wend_s;
  logic [8:0]  phy_a_s;
  logic [7:0]  phy_din_s, phy_dout_s;
  logic        phy_ba_s, phy_rfnb_s, phy_ready_s;

  memory_controller_burst_param #(.DATA_W(16), .ADDR_W(8), .MAX_BURST(4)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_s), .req_ready(req_ready_s), .req_we(req_we_s),
    .req_addr(req_addr_s), .req_len(req_len_s),
    .wdata(wdata_s), .wdata_valid(wdata_valid_s), .wdata_ready(wdata_ready_s),
    .rdata(rdata_s), .rdata_valid(rdata_valid_s), .done(done_s), .busy(busy_s), .err(err_s),
    .phy_rd(phy_rd_s), .phy_we(phy_we_s), .phy_rend(phy_rend_s), .phy_wend(phy_wend_s),
    .phy_a(phy_a_s), .phy_din(phy_din_s), .phy_dout(phy_dout_s),
    .phy_byte_available(phy_ba_s), .phy_ready_for_next_byte(phy_rfnb_s),
    .phy_ready(phy_ready_s)
  );

  int tests = 0;
  int fails = 0;
  int rv_cnt = 0, done_cnt = 0, wend_cnt = 0, rd_cnt = 0;

  always @(negedge clk) begin
    if (rdata_valid) rv_cnt++;
    if (done)        done_cnt++;
    if (phy_wend)    wend_cnt++;
    if (phy_rd)      rd_cnt++;
  end

  // Write-data feeder state, advanced inside tick() on each accepted handshake.
  logic [31:0] feed_words [4];
  int          feed_n = 0;
  int          feed_idx = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic hs;
    hs = wdata_valid && wdata_ready;
    @(posedge clk);
    #1;
    if (hs) begin
      feed_idx++;
      if (feed_idx < feed_n) wdata = feed_words[feed_idx];
      else                   wdata_valid = 1'b0;
    end
  endtask

  task automatic start_feed(input int n);
    feed_n      = n;
    feed_idx    = 0;
    wdata       = feed_words[0];
    wdata_valid = (n > 0);
  endtask

  function automatic logic [7:0] wbyte(input logic [31:0] w, input int k);
`ifdef MEMCTL_BYTESWAP_EN
    return w[8*k +: 8];
`else
    return w[31-8*k -: 8];
`endif
  endfunction

  function automatic logic [31:0] rword(input logic [7:0] b0, b1, b2, b3);
`ifdef MEMCTL_BYTESWAP_EN
    return {b3, b2, b1, b0};
`else
    return {b0, b1, b2, b3};
`endif
  endfunction

  // Leaves the caller just after the edge that captured the byte.
  task automatic read_byte(input logic [7:0] b);
    phy_dout = b;
    phy_byte_available = 1'b1;
    tick();
    phy_byte_available = 1'b0;
  endtask

  // Issue a read and step to the first XFER cycle, checking the start strobe.
  task automatic start_read(input logic [21:0] a, input logic [7:0] len, input string tag);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_len = len;
    tick();
    req_valid = 1'b0;
    tick();
    check({tag, "_phy_rd"}, phy_rd, 1);
    check({tag, "_phy_a"}, phy_a, {a, 2'b00});
    tick();
  endtask

  task automatic run_write(input logic [21:0] a, input logic [7:0] len, input int nbytes,
                           input logic exp_err, input string tag);
    logic [31:0] w;
    int d0, w0;
    d0 = done_cnt; w0 = wend_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_len = len;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    check({tag, "_phy_we"}, phy_we, 1);
    check({tag, "_phy_a"}, phy_a, {a, 2'b00});
    tick();
    for (int j = 0; j < nbytes; j++) begin
      w = (j / 4 < feed_n) ? feed_words[j / 4] : 32'h0;
      check($sformatf("%s_din%0d", tag, j), phy_din, wbyte(w, j % 4));
      phy_ready_for_next_byte = 1'b1;
      tick();
      phy_ready_for_next_byte = 1'b0;
      if (j == nbytes - 1) begin
        check({tag, "_done"}, done, 1);
        check({tag, "_wend"}, phy_wend, 1);
      end
      tick();
    end
    check({tag, "_err"}, err, exp_err);
    check({tag, "_done_once"}, done_cnt - d0, 1);
    check({tag, "_wend_once"}, wend_cnt - w0, 1);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
    wdata = '0; wdata_valid = 1'b0; phy_dout = '0;
    phy_byte_available = 1'b0; phy_ready_for_next_byte = 1'b0; phy_ready = 1'b1;
    req_valid_s = 1'b0; req_we_s = 1'b0; req_addr_s = '0; req_len_s = '0;
    wdata_s = '0; wdata_valid_s = 1'b0; phy_dout_s = '0;
    phy_ba_s = 1'b0; phy_rfnb_s = 1'b0; phy_ready_s = 1'b1;
    for (int i = 0; i < 4; i++) feed_words[i] = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_wdata_ready", wdata_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_rdata", rdata, 0);
    check("rst_phy_a", phy_a, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_req_ready", req_ready, 1);
    check("post_rst_wdata_ready", wdata_ready, 1);

    // Single read, len=0
    c0 = rv_cnt;
    start_read(22'h000123, 8'd0, "rd1");
    check("rd1_rd_pulse", phy_rd, 0);
    read_byte(8'h12); tick();
    read_byte(8'h34);
    check("rd1_rend_early", phy_rend, 0);
    tick();
    read_byte(8'h56);
    check("rd1_rend_before_last", phy_rend, 1);
    tick();
    read_byte(8'h78);
    check("rd1_rdata", rdata, rword(8'h12, 8'h34, 8'h56, 8'h78));
    check("rd1_rvalid", rdata_valid, 1);
    check("rd1_done", done, 1);
    tick();
    check("rd1_done_pulse", done, 0);
    check("rd1_rvalid_pulse", rdata_valid, 0);
    check("rd1_rvalid_once", rv_cnt - c0, 1);

    // Write burst len=3, all words supplied ahead
    feed_words[0] = 32'hA0A1A2A3; feed_words[1] = 32'hB0B1B2B3;
    feed_words[2] = 32'hC0C1C2C3; feed_words[3] = 32'hD0D1D2D3;
    start_feed(4);
    run_write(22'h000200, 8'd3, 16, 1'b0, "wr4");
    check("wr4_prefetch_empty", wdata_ready, 1);

    // Write len=1 with the second word withheld: underrun
    feed_words[0] = 32'h11223344;
    start_feed(1);
    run_write(22'h000040, 8'd1, 8, 1'b1, "wr_under");

    // Read with PHY busy for 20 cycles; acceptance clears err
    phy_ready = 1'b0;
    c0 = rd_cnt;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 22'h5; req_len = 8'd0;
    tick();
    req_valid = 1'b0;
    check("err_cleared", err, 0);
    repeat (20) tick();
    check("no_rd_while_phy_busy", rd_cnt - c0, 0);
    check("busy_waiting", busy, 1);
    phy_ready = 1'b1;
    tick();
    check("rd_after_ready", phy_rd, 1);
    tick();
    check("rd_single_pulse", phy_rd, 0);
    read_byte(8'hDE); tick();
    read_byte(8'hAD); tick();
    read_byte(8'hBE); tick();
    read_byte(8'hEF);
    check("rd2_rdata", rdata, rword(8'hDE, 8'hAD, 8'hBE, 8'hEF));
    check("rd2_rd_count", rd_cnt - c0, 1);
    tick();

    // Reset in the middle of a two-word read
    start_read(22'h0003FF, 8'd1, "rd3");
    read_byte(8'hAA); tick();
    read_byte(8'hBB); tick();
    read_byte(8'hCC); tick();
    read_byte(8'hDD);
    check("rd3_word0", rdata, rword(8'hAA, 8'hBB, 8'hCC, 8'hDD));
    tick();
    read_byte(8'hEE);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rdata", rdata, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_req_ready", req_ready, 0);
    check("mid_rst_phy_a", phy_a, 0);
    check("mid_rst_strobes", {rdata_valid, done, phy_rd, phy_we, phy_rend, phy_wend, err}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("after_rst_req_ready", req_ready, 1);
    start_read(22'h000007, 8'd0, "rd4");
    read_byte(8'h01); tick();
    read_byte(8'h02); tick();
    read_byte(8'h03); tick();
    read_byte(8'h04);
    check("rd4_rdata", rdata, rword(8'h01, 8'h02, 8'h03, 8'h04));
    check("rd4_done", done, 1);
    tick();

    // 16-bit instance read
    req_valid_s = 1'b1; req_addr_s = 8'h5A; req_len_s = 2'd0;
    tick();
    req_valid_s = 1'b0;
    tick();
    check("w16_phy_rd", phy_rd_s, 1);
    check("w16_phy_a", phy_a_s, 9'h0B4);
    tick();
    phy_dout_s = 8'h34; phy_ba_s = 1'b1;
    tick();
    phy_ba_s = 1'b0;
    check("w16_rend", phy_rend_s, 1);
    tick();
    phy_dout_s = 8'h12; phy_ba_s = 1'b1;
    tick();
    phy_ba_s = 1'b0;
`ifdef MEMCTL_BYTESWAP_EN
    check("w16_rdata", rdata_s, 16'h1234);
`else
    check("w16_rdata", rdata_s, 16'h3412);
`endif
    check("w16_rvalid", rdata_valid_s, 1);
    check("w16_done", done_s, 1);
    tick();
    check("w16_idle", busy_s, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/memory_controller_burst_param.md
# memory_controller_burst_param

Parametrised burst memory front-end between the CPU/bus side and the byte-serial PSRAM PHY (`psram_controller_fast`-style interface). It accepts one request (read or write, 1..MAX_BURST words of DATA_W bits) over a valid/ready handshake, serialises and deserialises words to and from the PHY byte stream, and reports completion and write-underrun errors. Unlike the fixed 32-bit pulse-handshake controller it replaces, word width, address width and burst depth are parameters, and write data is double-buffered with explicit backpressure.

## Interface
- `DATA_W`, 32, word width; multiple of 8, ≥8; BPW = DATA_W/8
- `ADDR_W`, 22, word address width
- `MAX_BURST`, 256, max words per request; power of two; LEN_W = clog2(MAX_BURST), minimum 1
- `clk`  in  1  sole clock
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  controller idle, accepts request
- `req_we`  in  1  1 = write, 0 = read
- `req_addr`  in  ADDR_W  start word address
- `req_len`  in  LEN_W  burst length minus 1, in words
- `wdata`  in  DATA_W  write word
- `wdata_valid`  in  1  write word present
- `wdata_ready`  out  1  prefetch slot empty
- `rdata`  out  DATA_W  read word
- `rdata_valid`  out  1  one-cycle pulse per read word; no backpressure
- `done`  out  1  one-cycle pulse at end of request
- `busy`  out  1  request in progress
- `err`  out  1  sticky write underrun; cleared on next request acceptance
- `phy_rd`, `phy_we`  out  1  one-cycle start strobes
- `phy_rend`, `phy_wend`  out  1  end-of-burst indications to PHY
- `phy_a`  out  ADDR_W+clog2(BPW)  byte address = {addr, zeros}
- `phy_din`  out  8  byte to PHY
- `phy_dout`  in  8  byte from PHY
- `phy_byte_available`, `phy_ready_for_next_byte`  in  1  level strobes; rising edge = one byte event
- `phy_ready`  in  1  PHY idle

## Operation
- States: IDLE, WAIT_PHY, START, XFER, FINISH.
- IDLE: `req_ready`=1. On `req_valid`: latch we/addr/len, clear `err` -> WAIT_PHY.
- WAIT_PHY: -> START when `phy_ready`=1 and (read, or write with a word in the shift register).
- START: `phy_rd` or `phy_we` high one cycle -> XFER.
- XFER read: each `phy_byte_available` rising edge shifts `phy_dout` into the assembly register; after BPW bytes, `rdata` updates and `rdata_valid` pulses. `phy_rend`=1 while remaining bytes in request ≤1 (from START when len=0 and BPW=1), held until IDLE.
- XFER write: `phy_din` always shows the current byte. Each `phy_ready_for_next_byte` rising edge consumes it. After the last byte of a word, the shift register reloads from prefetch on the same edge. If prefetch is empty on a word boundary with words remaining, it sends 0x00 for that word and sets `err`. The word counter still advances.
- After the final byte (read or write) -> FINISH: `phy_wend` high (write) one cycle, `done` pulses, -> IDLE.
- Byte order: MSB first (bits DATA_W-1:DATA_W-8 first) unless the byteswap macro is defined.
- Rising-edge detectors: previous-value registers reset to 0, so a level already high after reset counts as one event.
- Counters: byte index mod BPW; word counter LEN_W bits, counts down from len, terminal at 0 with byte index BPW-1.

## Timing
- Reset values: `req_ready`=0 during reset, then 1. All other outputs 0. `rdata`=0, `phy_a`=0.
- Request accept -> `phy_rd`/`phy_we` takes ≥2 cycles (WAIT_PHY, START).
- `rdata_valid` is asserted the cycle after the edge capturing the word's last byte.
- `wdata_ready` = prefetch empty, including in IDLE. This allows the first word, and the next word after WAIT_PHY loads the shift register.
- Write words are accepted on `wdata_valid`&`wdata_ready` only while busy or in IDLE with the prefetch empty. Excess words after the request ends stay in prefetch for the next write.
- `done` is asserted exactly one cycle after the final byte event. `busy`=!IDLE.
- Reset mid-operation: immediately abandons the transfer, and all strobes go to 0. The PHY must be reset together.

## Configuration
- `MEMCTL_BYTESWAP_EN` defined: bytes are serialised and assembled LSB first (bits 7:0 first), for little-endian PSRAM layout.
- Not defined: MSB first.

## Test plan
- Single read, DATA_W=32, len=0, PHY bytes 0x12,0x34,0x56,0x78 -> `rdata`=0x12345678, one `rdata_valid`, `phy_rend` asserted before the 4th byte, `done` one cycle after it.
- Write burst len=3, words 0xA0A1A2A3.. supplied ahead -> `phy_din` sequence A0,A1,A2,A3,B0..., 16 bytes, `phy_wend` and `done` once, `err`=0.
- Write len=1 with the second word withheld -> bytes 5..8 are 0x00, `err`=1. The next request clears `err`.
- `phy_ready`=0 for 20 cycles after accept -> no `phy_rd` until `phy_ready` rises, then `phy_rd` is a single pulse.
- `rst_n` low mid-read burst -> all outputs return to reset values in the same cycle. A following read completes correctly.
- DATA_W=16, MAX_BURST=4, with `MEMCTL_BYTESWAP_EN`: read bytes 0x34,0x12 -> `rdata`=0x1234.
